// File: rtl/reg_bank_reader.sv
// Register bank readout sequencer: walks a wrapping address range on the bank's
// read port and streams (address, data) words over a valid/ready handshake.
module reg_bank_reader #(
    parameter int DWIDTH = 32,
    parameter int WIDTH  = 5,
    parameter int RWIDTH = 16
) (
    input  logic              Clk,
    input  logic              N_Rst,
    input  logic              Start,
    input  logic [WIDTH-1:0]  StartAddr,
    input  logic [WIDTH:0]    NumRegs,
    input  logic              Abort,
    output logic [WIDTH-1:0]  RA,
    input  logic [DWIDTH-1:0] RD,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [WIDTH-1:0]  OutAddr,
    output logic [DWIDTH-1:0] OutData,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(RWIDTH - 1);
    localparam logic [WIDTH:0]   NUM_MAX   = (WIDTH + 1)'(RWIDTH);
    localparam logic [WIDTH:0]   ONE_LEFT  = (WIDTH + 1)'(1);

    state_t         state;
    logic [WIDTH:0] remaining;
    logic           request_legal;

    assign request_legal = ({1'b0, StartAddr} < NUM_MAX) &&
                           (NumRegs != '0) && (NumRegs <= NUM_MAX);

    assign Busy = (state == FETCH) || (state == SEND);

    // Abort wins over a same-cycle handshake, so it is tested first in FETCH/SEND.
    always_ff @(posedge Clk or negedge N_Rst) begin
        if (!N_Rst) begin
            state     <= IDLE;
            RA        <= '0;
            remaining <= '0;
            OutValid  <= 1'b0;
            OutAddr   <= '0;
            OutData   <= '0;
            Done      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            Done <= 1'b0;
            Err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (request_legal) begin
                            RA        <= StartAddr;
                            remaining <= NumRegs;
                            state     <= FETCH;
                        end else begin
                            Err <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (Abort) begin
                        OutValid <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        OutData  <= RD;
                        OutAddr  <= RA;
                        OutValid <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (Abort) begin
                        OutValid <= 1'b0;
                        state    <= IDLE;
                    end else if (OutReady) begin
                        OutValid <= 1'b0;
                        if (remaining == ONE_LEFT) begin
                            state <= DONE;
                        end else begin
                            remaining <= remaining - ONE_LEFT;
                            RA        <= (RA == LAST_ADDR) ? '0 : RA + 1'b1;
                            state     <= FETCH;
                        end
                    end
                end
                DONE: begin
                    Done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed bench for reg_bank_reader: table of dump requests plus hand-written
// backpressure, abort and reset sequences against a behavioural register bank.
module tb_reg_bank_reader;

    logic        Clk;
    logic        N_Rst;
    logic        Start;
    logic [4:0]  StartAddr;
    logic [5:0]  NumRegs;
    logic        Abort;
    logic [4:0]  RA;
    logic [31:0] RD;
    logic        OutValid;
    logic        OutReady;
    logic [4:0]  OutAddr;
    logic [31:0] OutData;
    logic        Busy;
    logic        Done;
    logic        Err;

    logic [31:0] bank [16];
    int compared;
    int mismatched;

    typedef struct {
        logic [4:0] start_addr;
        logic [5:0] num_regs;
        logic       exp_err;
        logic [4:0] exp_last;
    } vec_t;

    vec_t vecs [8];

    reg_bank_reader #(.DWIDTH(32), .WIDTH(5), .RWIDTH(16)) dut (
        .Clk       (Clk),
        .N_Rst     (N_Rst),
        .Start     (Start),
        .StartAddr (StartAddr),
        .NumRegs   (NumRegs),
        .Abort     (Abort),
        .RA        (RA),
        .RD        (RD),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutAddr   (OutAddr),
        .OutData   (OutData),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err)
    );

    assign RD = (RA < 5'd16) ? bank[RA[3:0]] : 32'h0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] sa, input logic [5:0] nr);
        Start     = 1'b1;
        StartAddr = sa;
        NumRegs   = nr;
        tick();
        Start     = 1'b0;
    endtask

    // Full-rate dump with OutReady held high; checks every word and the Done pulse.
    task automatic runDump(input logic [4:0] sa, input logic [5:0] nr, input logic [4:0] exp_last);
        logic [4:0] a;
        logic [4:0] last_seen;
        last_seen = '0;
        OutReady  = 1'b1;
        applyStimulus(sa, nr);
        checkOutput("busy_in_fetch", {31'b0, Busy}, 32'd1);
        checkOutput("valid_in_fetch", {31'b0, OutValid}, 32'd0);
        for (int w = 0; w < int'(nr); w++) begin
            a = 5'((int'(sa) + w) % 16);
            tick();
            checkOutput("word_valid", {31'b0, OutValid}, 32'd1);
            checkOutput("word_addr", {27'b0, OutAddr}, {27'b0, a});
            checkOutput("word_data", OutData, 32'h100 + 32'(a));
            last_seen = OutAddr;
            tick();
            checkOutput("valid_after_hs", {31'b0, OutValid}, 32'd0);
        end
        checkOutput("last_addr", {27'b0, last_seen}, {27'b0, exp_last});
        checkOutput("done_not_early", {31'b0, Done}, 32'd0);
        tick();
        checkOutput("done_pulse", {31'b0, Done}, 32'd1);
        checkOutput("busy_after_dump", {31'b0, Busy}, 32'd0);
        tick();
        checkOutput("done_one_cycle", {31'b0, Done}, 32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int k = 0; k < 16; k++) bank[k] = 32'h100 + 32'(k);

        vecs[0] = '{start_addr: 5'd2,  num_regs: 6'd3,  exp_err: 1'b0, exp_last: 5'd4};
        vecs[1] = '{start_addr: 5'd14, num_regs: 6'd4,  exp_err: 1'b0, exp_last: 5'd1};
        vecs[2] = '{start_addr: 5'd0,  num_regs: 6'd1,  exp_err: 1'b0, exp_last: 5'd0};
        vecs[3] = '{start_addr: 5'd15, num_regs: 6'd16, exp_err: 1'b0, exp_last: 5'd14};
        vecs[4] = '{start_addr: 5'd0,  num_regs: 6'd0,  exp_err: 1'b1, exp_last: 5'd0};
        vecs[5] = '{start_addr: 5'd0,  num_regs: 6'd17, exp_err: 1'b1, exp_last: 5'd0};
        vecs[6] = '{start_addr: 5'd16, num_regs: 6'd1,  exp_err: 1'b1, exp_last: 5'd0};
        vecs[7] = '{start_addr: 5'd31, num_regs: 6'd63, exp_err: 1'b1, exp_last: 5'd0};

        N_Rst     = 1'b0;
        Start     = 1'b0;
        StartAddr = '0;
        NumRegs   = '0;
        Abort     = 1'b0;
        OutReady  = 1'b0;
        tick();
        tick();
        checkOutput("rst_ra", {27'b0, RA}, 32'd0);
        checkOutput("rst_valid", {31'b0, OutValid}, 32'd0);
        checkOutput("rst_addr", {27'b0, OutAddr}, 32'd0);
        checkOutput("rst_data", OutData, 32'd0);
        checkOutput("rst_busy", {31'b0, Busy}, 32'd0);
        checkOutput("rst_done", {31'b0, Done}, 32'd0);
        checkOutput("rst_err", {31'b0, Err}, 32'd0);
        N_Rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].exp_err) begin
                applyStimulus(vecs[i].start_addr, vecs[i].num_regs);
                checkOutput("err_pulse", {31'b0, Err}, 32'd1);
                checkOutput("err_busy", {31'b0, Busy}, 32'd0);
                checkOutput("err_valid", {31'b0, OutValid}, 32'd0);
                tick();
                checkOutput("err_one_cycle", {31'b0, Err}, 32'd0);
                checkOutput("err_still_idle", {31'b0, Busy}, 32'd0);
            end else begin
                runDump(vecs[i].start_addr, vecs[i].num_regs, vecs[i].exp_last);
            end
        end

        // Backpressure on word 2, with bank writes before and after the fetches
        OutReady = 1'b1;
        applyStimulus(5'd0, 6'd3);
        tick();
        checkOutput("bp_w1_addr", {27'b0, OutAddr}, 32'd0);
        checkOutput("bp_w1_data", OutData, 32'h100);
        tick();
        OutReady = 1'b0;
        tick();
        bank[1] = 32'hDEAD_0001;
        bank[2] = 32'hBEEF_0002;
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_hold_valid", {31'b0, OutValid}, 32'd1);
            checkOutput("bp_hold_addr", {27'b0, OutAddr}, 32'd1);
            checkOutput("bp_hold_data", OutData, 32'h101);
            tick();
        end
        OutReady = 1'b1;
        tick();
        checkOutput("bp_w2_taken", {31'b0, OutValid}, 32'd0);
        tick();
        checkOutput("bp_w3_valid", {31'b0, OutValid}, 32'd1);
        checkOutput("bp_w3_addr", {27'b0, OutAddr}, 32'd2);
        checkOutput("bp_w3_data", OutData, 32'hBEEF_0002);
        tick();
        tick();
        checkOutput("bp_done", {31'b0, Done}, 32'd1);
        tick();
        for (int k = 0; k < 16; k++) bank[k] = 32'h100 + 32'(k);

        // Abort coinciding with a handshake on the first word
        OutReady = 1'b1;
        applyStimulus(5'd3, 6'd4);
        tick();
        checkOutput("ab_w1_addr", {27'b0, OutAddr}, 32'd3);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        checkOutput("ab_valid", {31'b0, OutValid}, 32'd0);
        checkOutput("ab_busy", {31'b0, Busy}, 32'd0);
        tick();
        checkOutput("ab_no_done", {31'b0, Done}, 32'd0);
        checkOutput("ab_idle", {31'b0, Busy}, 32'd0);
        runDump(5'd6, 6'd2, 5'd7);

        // Asynchronous reset in the middle of SEND
        OutReady = 1'b0;
        applyStimulus(5'd8, 6'd3);
        tick();
        checkOutput("rm_valid_before", {31'b0, OutValid}, 32'd1);
        #2;
        N_Rst = 1'b0;
        #1;
        checkOutput("rm_valid", {31'b0, OutValid}, 32'd0);
        checkOutput("rm_ra", {27'b0, RA}, 32'd0);
        checkOutput("rm_busy", {31'b0, Busy}, 32'd0);
        tick();
        N_Rst = 1'b1;
        tick();

        // Start while busy must be ignored, then the dump finishes normally
        applyStimulus(5'd4, 6'd2);
        tick();
        checkOutput("sb_w1_addr", {27'b0, OutAddr}, 32'd4);
        Start   = 1'b1;
        NumRegs = 6'd0;
        tick();
        Start   = 1'b0;
        checkOutput("sb_no_err", {31'b0, Err}, 32'd0);
        checkOutput("sb_hold_valid", {31'b0, OutValid}, 32'd1);
        checkOutput("sb_hold_addr", {27'b0, OutAddr}, 32'd4);
        OutReady = 1'b1;
        tick();
        tick();
        checkOutput("sb_w2_addr", {27'b0, OutAddr}, 32'd5);
        checkOutput("sb_w2_data", OutData, 32'h105);
        tick();
        tick();
        checkOutput("sb_done", {31'b0, Done}, 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
